// File: rtl/adsd_fetch_pkg.sv
// Shared types and constants for the ADSD instruction-fetch front end.
//   opcode_t / OPC_*  : 4-bit major opcodes the fetch unit may predecode
//   fetch_state_e     : fetch FSM states
//   fetch_entry_t     : {pc, instr} pair carried from fetch to decode
package adsd_fetch_pkg;

  localparam int unsigned FetchAddrW = 16;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OPC_JMP = 4'hE;
  localparam opcode_t OPC_BEQ = 4'h9;
  localparam opcode_t OPC_BGT = 4'hB;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } fetch_state_e;

  typedef struct packed {
    logic [FetchAddrW-1:0] pc;
    logic [15:0]           instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   flush_i           empty the FIFO; wins over push and pop
//   push_i/push_data_i  write an entry at the tail
//   pop_i             retire the head entry
//   head_data_o       head entry (valid only when valid_o)
//   valid_o           FIFO not empty
//   count_o           number of stored entries
module fetch_buf
  import adsd_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         head_data_o,
  output logic                     valid_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    count_d = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap by natural overflow.
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign valid_o     = (count_q != '0);
  assign count_o     = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: drives the instruction ROM, buffers fetched
// {pc, instr} pairs and hands them to decode over valid/ready.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   fetch_en_i                fetching permitted
//   rom_addr_o, rom_oe_o      ROM word address (always pc) and output enable
//   rom_data_i                combinational ROM read data
//   inst_valid_o/inst_ready_i decode handshake; inst_o / inst_pc_o is the head
//   redirect_valid_i/_pc_i    PC change from execute (flushes the buffer)
// Optional feature: define FETCH_JMP_PREDECODE_EN to follow jmp targets at
// fetch time instead of waiting for execute's redirect.
module instr_fetch_unit
  import adsd_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_en_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_oe_o,
  input  logic [15:0]       rom_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [15:0]       inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  localparam int unsigned CntW    = $clog2(BUF_DEPTH) + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(BUF_DEPTH);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] hold_pc_q;
  logic [15:0]       hold_instr_q;

  logic                 buf_valid;
  logic [CntW-1:0]      buf_count;
  logic [ADDR_W+15:0]   buf_head;
  logic                 full, pop, fetch;

  always_comb begin
    full = (buf_count == FullCnt);
    // Redirect discards a simultaneous pop; reset overrides everything.
    pop   = buf_valid & inst_ready_i & ~redirect_valid_i & ~rst_i;
    fetch = (state_q == StRun) & fetch_en_i & ~redirect_valid_i & ~rst_i & (~full | pop);

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (fetch_en_i)  state_d = StRun;
      StRun:   if (!fetch_en_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
    end else if (fetch) begin
      pc_d = pc_q + ADDR_W'(1);
`ifdef FETCH_JMP_PREDECODE_EN
      if (opcode_t'(rom_data_i[15:12]) == OPC_JMP) pc_d = ADDR_W'(rom_data_i[11:0]);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      // Keep whatever decode last saw so inst/inst_pc hold while empty.
      hold_pc_q    <= inst_pc_o;
      hold_instr_q <= inst_o;
    end
  end

  fetch_buf #(
    .Depth (BUF_DEPTH),
    .Width (ADDR_W + 16)
  ) u_fetch_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_valid_i),
    .push_i      (fetch),
    .push_data_i ({pc_q, rom_data_i}),
    .pop_i       (pop),
    .head_data_o (buf_head),
    .valid_o     (buf_valid),
    .count_o     (buf_count)
  );

  assign rom_addr_o   = pc_q;
  assign rom_oe_o     = fetch;
  assign inst_valid_o = buf_valid;
  assign inst_o       = buf_valid ? buf_head[15:0]         : hold_instr_q;
  assign inst_pc_o    = buf_valid ? buf_head[ADDR_W+15:16] : hold_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, fetch_en, inst_ready, redirect_valid;
  logic [15:0] redirect_pc, rom_addr, rom_data, inst, inst_pc;
  logic        rom_oe, inst_valid;

  logic [15:0] rom [512];
  assign rom_data = rom[rom_addr[8:0]];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W    (16),
    .RESET_PC  (16'h0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .fetch_en_i       (fetch_en),
    .rom_addr_o       (rom_addr),
    .rom_oe_o         (rom_oe),
    .rom_data_i       (rom_data),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_ready),
    .inst_o           (inst),
    .inst_pc_o        (inst_pc),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc)
  );

`ifdef FETCH_JMP_PREDECODE_EN
  localparam logic [15:0] J = 16'd4;   // jmp at 9 followed at fetch time
`else
  localparam logic [15:0] J = 16'd10;  // sequential past the jmp
`endif

  typedef struct {
    logic        rst, en, rdy, redir;
    logic [15:0] rpc;
    logic        oe;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] ipc;
  } vec_t;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } sb_t;

  vec_t vecs[35];
  sb_t  sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic r, logic e, logic y, logic d, logic [15:0] rp,
                              logic o, logic [15:0] a, logic v, logic [15:0] ip);
    vec_t t;
    t.rst = r; t.en = e; t.rdy = y; t.redir = d; t.rpc = rp;
    t.oe = o; t.addr = a; t.valid = v; t.ipc = ip;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = {4'hA, 3'b000, i[8:0]};
    rom[9] = 16'hE004;

    //               rst en rdy rd rpc       oe addr      v  ipc
    vecs[0]  = mk(0, 1, 1, 0, 16'h0,    0, 16'h0000, 0, 16'h0000);
    vecs[1]  = mk(0, 1, 1, 0, 16'h0,    1, 16'h0000, 0, 16'h0000);
    vecs[2]  = mk(0, 1, 1, 0, 16'h0,    1, 16'h0001, 1, 16'h0000);
    vecs[3]  = mk(0, 1, 1, 0, 16'h0,    1, 16'h0002, 1, 16'h0001);
    vecs[4]  = mk(0, 1, 1, 0, 16'h0,    1, 16'h0003, 1, 16'h0002);
    vecs[5]  = mk(1, 1, 1, 0, 16'h0,    0, 16'h0004, 1, 16'h0003);
    vecs[6]  = mk(0, 1, 0, 0, 16'h0,    0, 16'h0000, 0, 16'h0000);
    vecs[7]  = mk(0, 1, 0, 0, 16'h0,    1, 16'h0000, 0, 16'h0000);
    vecs[8]  = mk(0, 1, 0, 0, 16'h0,    1, 16'h0001, 1, 16'h0000);
    vecs[9]  = mk(0, 1, 0, 0, 16'h0,    0, 16'h0002, 1, 16'h0000);
    vecs[10] = mk(0, 1, 0, 0, 16'h0,    0, 16'h0002, 1, 16'h0000);
    vecs[11] = mk(0, 1, 0, 0, 16'h0,    0, 16'h0002, 1, 16'h0000);
    vecs[12] = mk(0, 1, 1, 0, 16'h0,    1, 16'h0002, 1, 16'h0000);
    vecs[13] = mk(0, 1, 1, 0, 16'h0,    1, 16'h0003, 1, 16'h0001);
    vecs[14] = mk(0, 1, 1, 0, 16'h0,    1, 16'h0004, 1, 16'h0002);
    vecs[15] = mk(0, 1, 1, 1, 16'h0014, 0, 16'h0005, 1, 16'h0003);
    vecs[16] = mk(0, 1, 1, 0, 16'h0,    1, 16'h0014, 0, 16'h0003);
    vecs[17] = mk(0, 1, 1, 0, 16'h0,    1, 16'h0015, 1, 16'h0014);
    vecs[18] = mk(0, 1, 1, 1, 16'hFFFF, 0, 16'h0016, 1, 16'h0015);
    vecs[19] = mk(0, 1, 1, 0, 16'h0,    1, 16'hFFFF, 0, 16'h0015);
    vecs[20] = mk(0, 1, 1, 0, 16'h0,    1, 16'h0000, 1, 16'hFFFF);
    vecs[21] = mk(0, 1, 1, 0, 16'h0,    1, 16'h0001, 1, 16'h0000);
    vecs[22] = mk(0, 1, 1, 1, 16'h0008, 0, 16'h0002, 1, 16'h0001);
    vecs[23] = mk(0, 1, 1, 0, 16'h0,    1, 16'h0008, 0, 16'h0001);
    vecs[24] = mk(0, 1, 1, 0, 16'h0,    1, 16'h0009, 1, 16'h0008);
    vecs[25] = mk(0, 1, 1, 0, 16'h0,    1, J,        1, 16'h0009);
    vecs[26] = mk(0, 1, 1, 0, 16'h0,    1, J + 16'd1, 1, J);
    vecs[27] = mk(0, 0, 0, 0, 16'h0,    0, J + 16'd2, 1, J + 16'd1);
    vecs[28] = mk(0, 0, 1, 0, 16'h0,    0, J + 16'd2, 1, J + 16'd1);
    vecs[29] = mk(0, 0, 1, 0, 16'h0,    0, J + 16'd2, 0, J + 16'd1);
    vecs[30] = mk(0, 1, 1, 0, 16'h0,    0, J + 16'd2, 0, J + 16'd1);
    vecs[31] = mk(0, 1, 1, 0, 16'h0,    1, J + 16'd2, 0, J + 16'd1);
    vecs[32] = mk(1, 0, 1, 1, 16'h0040, 0, J + 16'd3, 1, J + 16'd2);
    vecs[33] = mk(0, 0, 1, 0, 16'h0,    0, 16'h0000, 0, 16'h0000);
    vecs[34] = mk(0, 0, 1, 0, 16'h0,    0, 16'h0000, 0, 16'h0000);

    rst = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, fetch disabled.
    @(negedge clk);
    check("reset_valid", {31'b0, inst_valid}, 32'd0);
    check("reset_oe", {31'b0, rom_oe}, 32'd0);
    check("reset_addr", {16'b0, rom_addr}, 32'd0);
    check("reset_inst", {16'b0, inst}, 32'd0);
    check("reset_inst_pc", {16'b0, inst_pc}, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 35; i++) begin
      rst = vecs[i].rst; fetch_en = vecs[i].en; inst_ready = vecs[i].rdy;
      redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
      @(negedge clk);
      check($sformatf("row%0d_oe", i), {31'b0, rom_oe}, {31'b0, vecs[i].oe});
      check($sformatf("row%0d_addr", i), {16'b0, rom_addr}, {16'b0, vecs[i].addr});
      check($sformatf("row%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].valid});
      check($sformatf("row%0d_inst_pc", i), {16'b0, inst_pc}, {16'b0, vecs[i].ipc});

      // Scoreboard: retire the head first, then enqueue this cycle's fetch.
      if (vecs[i].valid && vecs[i].rdy && !vecs[i].redir && !vecs[i].rst) begin
        if (sbq.size() == 0) begin
          check($sformatf("row%0d_sb_empty", i), 32'd0, 32'd1);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          check($sformatf("row%0d_sb_pc", i), {16'b0, inst_pc}, {16'b0, e.pc});
          check($sformatf("row%0d_sb_inst", i), {16'b0, inst}, {16'b0, e.instr});
        end
      end
      if (vecs[i].rst || vecs[i].redir) sbq.delete();
      if (vecs[i].oe) begin
        sb_t n;
        n.pc = vecs[i].addr;
        n.instr = rom[vecs[i].addr[8:0]];
        sbq.push_back(n);
      end
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
